// File: rtl/recon_sched_pkg.sv
// Shared types and sizing for the per-macroblock reconstruction scheduler.
package recon_sched_pkg;

  localparam int unsigned DERR_W          = 32;
  localparam int unsigned COORD_W         = 10;
  localparam int unsigned MAX_MB_COLS_DEF = 256;
  localparam int unsigned TIMEOUT_DEF     = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_COMMIT,
    ST_FINISH
  } sched_state_e;

endpackage

// File: rtl/recon_mb_sched_if.sv
// MB descriptor handshake plus completion status between issuer and scheduler.
interface recon_mb_sched_if;
  import recon_sched_pkg::*;

  logic               mb_valid;
  logic               mb_ready;
  logic [COORD_W-1:0] mb_x;
  logic [COORD_W-1:0] mb_y;
  logic               mb_done;
  logic               mb_err;

  modport master (output mb_valid, mb_x, mb_y, input  mb_ready, mb_done, mb_err);
  modport slave  (input  mb_valid, mb_x, mb_y, output mb_ready, mb_done, mb_err);
endinterface

// File: rtl/derr_top_store.sv
// Per-column chroma top DC-error store: sync write, registered read, old data on collision.
module derr_top_store #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is never cleared; row-0 masking on the read side hides stale contents.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_addr];
  end

endmodule

// File: rtl/recon_mb_sched.sv
// Launches luma/chroma reconstruct engines per MB, waits for both, commits chroma DC-error state.
module recon_mb_sched
  import recon_sched_pkg::*;
#(
  parameter int unsigned MAX_MB_COLS = MAX_MB_COLS_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  recon_mb_sched_if.slave    mb,
  output logic [COORD_W-1:0] eng_x,
  output logic [COORD_W-1:0] eng_y,
  output logic               y_start,
  input  logic               y_done,
  output logic               uv_start,
  input  logic               uv_done,
  output logic [DERR_W-1:0]  uv_left_derr,
  input  logic               uv_top_derr_en,
  input  logic [COORD_W-1:0] uv_top_derr_addr,
  output logic [DERR_W-1:0]  uv_top_derr,
  input  logic [DERR_W-1:0]  uv_left_derr_new,
  input  logic [DERR_W-1:0]  uv_top_derr_new,
  output logic               busy
);

  localparam int unsigned AW = (MAX_MB_COLS > 1) ? $clog2(MAX_MB_COLS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  sched_state_e      state_q, state_d;
  logic              y_seen_q, y_seen_d, uv_seen_q, uv_seen_d;
  logic              err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              y_done_q, uv_done_q;
  logic              y_edge, uv_edge;
  logic              accept, uv_cap, commit_we, col_ok, rd_zero;
  logic [DERR_W-1:0] left_hold_q, top_hold_q;

  // Rising edges only, so a done level held over from the previous job never counts.
  assign y_edge  = y_done  & ~y_done_q;
  assign uv_edge = uv_done & ~uv_done_q;
  assign col_ok  = 32'(eng_x) < MAX_MB_COLS;
  assign rd_zero = (eng_y == '0) || (32'(uv_top_derr_addr) >= MAX_MB_COLS);

  always_comb begin
    state_d   = state_q;
    y_seen_d  = y_seen_q;
    uv_seen_d = uv_seen_q;
    timer_d   = timer_q;
    err_d     = err_q;
    accept    = 1'b0;
    uv_cap    = 1'b0;
    commit_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mb.mb_valid) begin
          accept  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        y_seen_d  = 1'b0;
        uv_seen_d = 1'b0;
        timer_d   = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        y_seen_d  = y_seen_q | y_edge;
        uv_seen_d = uv_seen_q | uv_edge;
        uv_cap    = uv_edge;
        if (y_seen_d && uv_seen_d) begin
          state_d = ST_COMMIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_COMMIT: begin
        if (col_ok) commit_we = 1'b1;
        else        err_d     = 1'b1;
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      y_seen_q     <= 1'b0;
      uv_seen_q    <= 1'b0;
      err_q        <= 1'b0;
      timer_q      <= '0;
      y_done_q     <= 1'b0;
      uv_done_q    <= 1'b0;
      left_hold_q  <= '0;
      top_hold_q   <= '0;
      eng_x        <= '0;
      eng_y        <= '0;
      uv_left_derr <= '0;
      y_start      <= 1'b0;
      uv_start     <= 1'b0;
      busy         <= 1'b0;
      mb.mb_ready  <= 1'b1;
      mb.mb_done   <= 1'b0;
      mb.mb_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_seen_q    <= y_seen_d;
      uv_seen_q   <= uv_seen_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      y_done_q    <= y_done;
      uv_done_q   <= uv_done;
      if (uv_cap) begin
        left_hold_q <= uv_left_derr_new;
        top_hold_q  <= uv_top_derr_new;
      end
      if (accept) begin
        eng_x <= mb.mb_x;
        eng_y <= mb.mb_y;
        if (mb.mb_x == '0) uv_left_derr <= '0;
      end
      if (commit_we) uv_left_derr <= left_hold_q;
      y_start     <= (state_d == ST_LAUNCH);
      uv_start    <= (state_d == ST_LAUNCH);
      busy        <= (state_d != ST_IDLE);
      mb.mb_ready <= (state_d == ST_IDLE);
      mb.mb_done  <= (state_d == ST_FINISH);
      mb.mb_err   <= (state_d == ST_FINISH) && err_d;
    end
  end

  derr_top_store #(
    .DEPTH (MAX_MB_COLS),
    .WIDTH (DERR_W),
    .AW    (AW)
  ) u_top_store (
    .clk     (clk),
    .rst     (rst),
    .we      (commit_we),
    .wr_addr (eng_x[AW-1:0]),
    .wr_data (top_hold_q),
    .rd_en   (uv_top_derr_en),
    .rd_zero (rd_zero),
    .rd_addr (uv_top_derr_addr[AW-1:0]),
    .rd_data (uv_top_derr)
  );

endmodule

// File: tb/tb_recon_mb_sched.sv
// Directed bench: two schedulers (long and short timeout) driven with identical stimulus.
module tb_recon_mb_sched;
  import recon_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               mb_valid;
  logic [COORD_W-1:0] mb_x, mb_y;
  logic               y_done, uv_done, en;
  logic [COORD_W-1:0] addr;
  logic [DERR_W-1:0]  left_new, top_new;

  logic [COORD_W-1:0] eng_x, eng_y, eng_x2, eng_y2;
  logic               y_start, uv_start, busy, y_start2, uv_start2, busy2;
  logic [DERR_W-1:0]  left, top, left2, top2;

  recon_mb_sched_if ifc ();
  recon_mb_sched_if ifc2 ();
  assign ifc.mb_valid  = mb_valid;
  assign ifc.mb_x      = mb_x;
  assign ifc.mb_y      = mb_y;
  assign ifc2.mb_valid = mb_valid;
  assign ifc2.mb_x     = mb_x;
  assign ifc2.mb_y     = mb_y;

  recon_mb_sched #(.MAX_MB_COLS(256), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .mb(ifc),
    .eng_x(eng_x), .eng_y(eng_y),
    .y_start(y_start), .y_done(y_done), .uv_start(uv_start), .uv_done(uv_done),
    .uv_left_derr(left), .uv_top_derr_en(en), .uv_top_derr_addr(addr), .uv_top_derr(top),
    .uv_left_derr_new(left_new), .uv_top_derr_new(top_new), .busy(busy)
  );

  recon_mb_sched #(.MAX_MB_COLS(256), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst), .mb(ifc2),
    .eng_x(eng_x2), .eng_y(eng_y2),
    .y_start(y_start2), .y_done(y_done), .uv_start(uv_start2), .uv_done(uv_done),
    .uv_left_derr(left2), .uv_top_derr_en(en), .uv_top_derr_addr(addr), .uv_top_derr(top2),
    .uv_left_derr_new(left_new), .uv_top_derr_new(top_new), .busy(busy2)
  );

  int n_vec = 0;
  int n_err = 0;
  int ys_cnt = 0;
  int uvs_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (y_start)     ys_cnt   <= ys_cnt + 1;
    if (uv_start)    uvs_cnt  <= uvs_cnt + 1;
    if (ifc.mb_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [COORD_W-1:0] a, output logic [DERR_W-1:0] d, output logic [DERR_W-1:0] d2);
    en   = 1'b1;
    addr = a;
    tick();
    en = 1'b0;
    d  = top;
    d2 = top2;
  endtask

  // Issues one MB; done edges are raised at loop iteration yd/uvd (0 = never).
  task automatic run_mb(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                        input logic [DERR_W-1:0] ln, input logic [DERR_W-1:0] tn,
                        input int yd, input int uvd,
                        output int lat, output logic err, output int lat2, output logic err2,
                        output logic rdy2, output logic [DERR_W-1:0] left_launch);
    lat = 0; lat2 = 0; err = 1'b0; err2 = 1'b0; rdy2 = 1'b0;
    mb_valid = 1'b1; mb_x = x; mb_y = y; y_done = 1'b0; uv_done = 1'b0;
    tick();
    mb_valid = 1'b0;
    left_launch = left;
    for (int i = 1; i <= 300; i++) begin
      if (i == yd) y_done = 1'b1;
      if (i == uvd) begin
        uv_done = 1'b1; left_new = ln; top_new = tn;
      end
      tick();
      if (lat2 != 0 && i == lat2 + 1) rdy2 = ifc2.mb_ready;
      if (ifc2.mb_done && lat2 == 0) begin
        lat2 = i; err2 = ifc2.mb_err;
      end
      if (ifc.mb_done) begin
        lat = i; err = ifc.mb_err;
        break;
      end
    end
    tick();
  endtask

  int                d0, s0, u0, lat, lat2, done_at;
  logic              err, err2, rdy2;
  logic [DERR_W-1:0] d, dd2, ll;

  initial begin
    rst = 1'b1; mb_valid = 1'b0; mb_x = '0; mb_y = '0; y_done = 1'b0; uv_done = 1'b0;
    en = 1'b0; addr = '0; left_new = '0; top_new = '0;
    repeat (3) tick();
    check_eq("rst_ready",  64'(ifc.mb_ready), 64'd1);
    check_eq("rst_busy",   64'(busy), 64'd0);
    check_eq("rst_ystart", 64'(y_start), 64'd0);
    check_eq("rst_done",   64'(ifc.mb_done), 64'd0);
    check_eq("rst_err",    64'(ifc.mb_err), 64'd0);
    check_eq("rst_engx",   64'(eng_x), 64'd0);
    check_eq("rst_left",   64'(left), 64'd0);
    check_eq("rst_top",    64'(top), 64'd0);
    rst = 1'b0;
    tick();

    // Single MB x=3 y=2
    s0 = ys_cnt; u0 = uvs_cnt; d0 = done_cnt;
    mb_valid = 1'b1; mb_x = 10'd3; mb_y = 10'd2;
    tick();
    mb_valid = 1'b0;
    check_eq("t1_ystart",  64'(y_start), 64'd1);
    check_eq("t1_uvstart", 64'(uv_start), 64'd1);
    check_eq("t1_engx",    64'(eng_x), 64'd3);
    check_eq("t1_engy",    64'(eng_y), 64'd2);
    check_eq("t1_ready",   64'(ifc.mb_ready), 64'd0);
    done_at = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 20) y_done = 1'b1;
      if (i == 37) begin
        uv_done = 1'b1; left_new = 32'h11; top_new = 32'h22;
      end
      tick();
      if (ifc.mb_done) begin
        done_at = i; err = ifc.mb_err;
        break;
      end
    end
    check_eq("t1_done_at", 64'(done_at), 64'd38);
    check_eq("t1_err",     64'(err), 64'd0);
    check_eq("t1_left",    64'(left), 64'h11);
    tick();
    check_eq("t1_ready_after", 64'(ifc.mb_ready), 64'd1);
    check_eq("t1_ystart_cnt",  64'(ys_cnt - s0), 64'd1);
    check_eq("t1_uvstart_cnt", 64'(uvs_cnt - u0), 64'd1);
    check_eq("t1_done_cnt",    64'(done_cnt - d0), 64'd1);
    rd(10'd3, d, dd2);
    check_eq("t1_top3", 64'(d), 64'h22);

    // Row-0 masking and column boundaries
    run_mb(10'd5, 10'd1, 32'h5A, 32'hAB, 5, 3, lat, err, lat2, err2, rdy2, ll);
    check_eq("t2_lat", 64'(lat), 64'd6);
    rd(10'd5, d, dd2);
    check_eq("t2_top5_row1", 64'(d), 64'hAB);
    run_mb(10'd6, 10'd0, 32'h61, 32'h60, 3, 3, lat, err, lat2, err2, rdy2, ll);
    check_eq("t2_lat_row0", 64'(lat), 64'd4);
    rd(10'd5, d, dd2);
    check_eq("t2_top5_row0", 64'(d), 64'h0);
    run_mb(10'd7, 10'd1, 32'h71, 32'h70, 2, 2, lat, err, lat2, err2, rdy2, ll);
    check_eq("t2_lat_both2", 64'(lat), 64'd3);
    rd(10'd5, d, dd2);
    check_eq("t2_top5_again", 64'(d), 64'hAB);
    rd(10'd256, d, dd2);
    check_eq("t2_addr_oob", 64'(d), 64'h0);
    run_mb(10'd255, 10'd1, 32'h01, 32'hFF0, 2, 3, lat, err, lat2, err2, rdy2, ll);
    check_eq("t2_x255_err", 64'(err), 64'd0);
    rd(10'd255, d, dd2);
    check_eq("t2_top255", 64'(d), 64'hFF0);
    run_mb(10'd300, 10'd1, 32'h02, 32'h3A, 2, 2, lat, err, lat2, err2, rdy2, ll);
    check_eq("t2_x300_lat",  64'(lat), 64'd3);
    check_eq("t2_x300_err",  64'(err), 64'd1);
    check_eq("t2_x300_left", 64'(left), 64'h01);

    // Left reset on column 0
    run_mb(10'd4, 10'd1, 32'h55, 32'h44, 3, 6, lat, err, lat2, err2, rdy2, ll);
    check_eq("t3_lat",  64'(lat), 64'd7);
    check_eq("t3_left", 64'(left), 64'h55);
    run_mb(10'd0, 10'd1, 32'h66, 32'h60, 4, 4, lat, err, lat2, err2, rdy2, ll);
    check_eq("t3_left_launch", 64'(ll), 64'h0);
    check_eq("t3_left_x0",     64'(left), 64'h66);

    // Stale done levels, then simultaneous edges; read during COMMIT returns old data
    d0 = done_cnt;
    mb_valid = 1'b1; mb_x = 10'd3; mb_y = 10'd2;
    tick();
    mb_valid = 1'b0;
    repeat (6) tick();
    check_eq("t4_no_early", 64'(done_cnt - d0), 64'd0);
    check_eq("t4_busy",     64'(busy), 64'd1);
    y_done = 1'b0; uv_done = 1'b0;
    tick();
    y_done = 1'b1; uv_done = 1'b1; left_new = 32'h77; top_new = 32'h33;
    tick();
    en = 1'b1; addr = 10'd3;
    tick();
    en = 1'b0;
    check_eq("t4_done",    64'(ifc.mb_done), 64'd1);
    check_eq("t4_err",     64'(ifc.mb_err), 64'd0);
    check_eq("t4_rbw_old", 64'(top), 64'h22);
    check_eq("t4_left",    64'(left), 64'h77);
    tick();
    check_eq("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    rd(10'd3, d, dd2);
    check_eq("t4_top3_new", 64'(d), 64'h33);

    // Timeout
    run_mb(10'd2, 10'd1, 32'h21, 32'h77, 3, 5, lat, err, lat2, err2, rdy2, ll);
    check_eq("t5_pre_lat2", 64'(lat2), 64'd6);
    check_eq("t5_pre_err2", 64'(err2), 64'd0);
    run_mb(10'd2, 10'd1, 32'h12, 32'h99, 0, 4, lat, err, lat2, err2, rdy2, ll);
    check_eq("t5_to16_lat",   64'(lat2), 64'd17);
    check_eq("t5_to16_err",   64'(err2), 64'd1);
    check_eq("t5_to16_ready", 64'(rdy2), 64'd1);
    check_eq("t5_to64_lat",   64'(lat), 64'd65);
    check_eq("t5_to64_err",   64'(err), 64'd1);
    rd(10'd2, d, dd2);
    check_eq("t5_top2_to16", 64'(dd2), 64'h77);
    check_eq("t5_top2_to64", 64'(d), 64'h77);
    check_eq("t5_left_to16", 64'(left2), 64'h21);

    // Reset in the middle of WAIT
    mb_valid = 1'b1; mb_x = 10'd9; mb_y = 10'd3; y_done = 1'b0; uv_done = 1'b0;
    tick();
    mb_valid = 1'b0;
    repeat (3) tick();
    check_eq("t6_busy_pre", 64'(busy), 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_busy",  64'(busy), 64'd0);
    check_eq("t6_ready", 64'(ifc.mb_ready), 64'd1);
    check_eq("t6_left",  64'(left), 64'h0);
    check_eq("t6_engx",  64'(eng_x), 64'h0);
    repeat (4) tick();
    check_eq("t6_no_done", 64'(done_cnt - d0), 64'd0);
    run_mb(10'd9, 10'd3, 32'h5, 32'h6, 4, 2, lat, err, lat2, err2, rdy2, ll);
    check_eq("t6_lat", 64'(lat), 64'd5);
    check_eq("t6_err", 64'(err), 64'd0);
    rd(10'd9, d, dd2);
    check_eq("t6_top9", 64'(d), 64'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
